// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter_if
// Description : Avalon-MM signal bundle for the two-master SDRAM port arbiter.
//               Carries the VGA (m0), GPU (m1) and SDRAM (s) buses.
//               The "slave" modport is the arbiter's view. The "master"
//               modport is the view of the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_port_arbiter_if;
    // VGA scanout reader (read-only)
    logic [31:0] m0_address;
    logic        m0_read;
    logic [31:0] m0_readdata;
    logic        m0_waitrequest;
    logic        m0_readdatavalid;

    // GPU / rasteriser (read/write)
    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_readdata;
    logic        m1_waitrequest;
    logic        m1_readdatavalid;

    // Shared SDRAM controller port
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic        s_readdatavalid;

    modport slave (
        input  m0_address, m0_read,
        output m0_readdata, m0_waitrequest, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_readdata, m1_waitrequest, m1_readdatavalid,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_readdata, s_waitrequest, s_readdatavalid
    );

    modport master (
        output m0_address, m0_read,
        input  m0_readdata, m0_waitrequest, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_readdata, m1_waitrequest, m1_readdatavalid,
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_readdata, s_waitrequest, s_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one SDRAM Avalon-MM port between a high-priority VGA
//               reader (m0) and a GPU read/write master (m1). Ownership is
//               bounded by MAX_BURST accepts when the other master waits, and
//               a tag FIFO routes pipelined read data back to its issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int MAX_BURST   = 16,  // 1..255
    parameter int MAX_PENDING = 8    // power of 2, 2..32
) (
    input  wire                   clk,
    input  wire                   resetn,
    sdram_port_arbiter_if.slave   bus,
    output logic [5:0]            pending,
    output logic                  err_orphan
);

    localparam int c_ptr_w = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_max_pending = c_cnt_w'(MAX_PENDING);
    localparam logic [7:0]         c_max_burst   = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_burst_cnt;

    logic [MAX_PENDING-1:0] r_tags;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_err_orphan;

    logic                w_req0;
    logic                w_req1;
    logic                w_own0;
    logic                w_own1;
    logic                w_owner_req;
    logic                w_other_req;
    logic                w_owner_rd;
    logic                w_full;
    logic                w_empty;
    logic                w_blocked;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_head_tag;
    logic [7:0]          w_burst_inc;

    // Request decode; an M1 read+write collision is treated as a read
    assign w_req0      = bus.m0_read;
    assign w_req1      = bus.m1_read | bus.m1_write;
    assign w_own0      = (r_state == OWN0);
    assign w_own1      = (r_state == OWN1);
    assign w_owner_req = (w_own0 & w_req0) | (w_own1 & w_req1);
    assign w_other_req = w_own0 ? w_req1 : w_req0;
    assign w_owner_rd  = (w_own0 & bus.m0_read) | (w_own1 & bus.m1_read);

    // Read tag FIFO status; a full FIFO stalls reads but never writes
    assign w_full      = (r_count == c_max_pending);
    assign w_empty     = (r_count == '0);
    assign w_blocked   = w_owner_rd & w_full;
    assign w_accept    = w_owner_req & ~bus.s_waitrequest & ~w_blocked;
    assign w_push      = w_accept & w_owner_rd;
    assign w_pop       = bus.s_readdatavalid & ~w_empty;
    assign w_head_tag  = r_tags[r_rd_ptr];

    // Burst counter saturates so a long uncontested run cannot wrap
    assign w_burst_inc = (r_burst_cnt >= c_max_burst) ? c_max_burst : (r_burst_cnt + 8'd1);

    // Command forwarding to the SDRAM port; all zero outside ownership
    assign bus.s_read       = w_owner_rd & ~w_full;
    assign bus.s_write      = w_own1 & bus.m1_write & ~bus.m1_read;
    assign bus.s_address    = w_own0 ? bus.m0_address : (w_own1 ? bus.m1_address : 32'h0);
    assign bus.s_writedata  = w_own1 ? bus.m1_writedata : 32'h0;
    assign bus.s_byteenable = w_own0 ? 4'hF : (w_own1 ? bus.m1_byteenable : 4'h0);

    // Stall and response routing back to the masters
    assign bus.m0_waitrequest   = w_own0 ? (bus.s_waitrequest | w_blocked) : 1'b1;
    assign bus.m1_waitrequest   = w_own1 ? (bus.s_waitrequest | w_blocked) : 1'b1;
    assign bus.m0_readdata      = bus.s_readdata;
    assign bus.m1_readdata      = bus.s_readdata;
    assign bus.m0_readdatavalid = bus.s_readdatavalid & ~w_empty & ~w_head_tag;
    assign bus.m1_readdatavalid = bus.s_readdatavalid & ~w_empty &  w_head_tag;

    assign pending    = 6'(r_count);
    assign err_orphan = r_err_orphan;

    // Ownership FSM: hands over only between accepted commands, never mid-stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_burst_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_burst_cnt <= 8'd0;
                    if (w_req0) begin
                        r_state <= OWN0;
                    end else if (w_req1) begin
                        r_state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (w_owner_req) begin
                        if (w_accept) begin
                            if (w_other_req && (w_burst_inc == c_max_burst)) begin
                                r_state     <= w_own0 ? OWN1 : OWN0;
                                r_burst_cnt <= 8'd0;
                            end else begin
                                r_burst_cnt <= w_burst_inc;
                            end
                        end
                    end else begin
                        r_burst_cnt <= 8'd0;
                        if (w_other_req) begin
                            r_state <= w_own0 ? OWN1 : OWN0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_burst_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Outstanding-read tag FIFO plus sticky orphan-response flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tags       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_own1;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.s_readdatavalid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Self-checking bench for sdram_port_arbiter. A scoreboard
//               queues the expected read responses as master reads are
//               accepted. It pops and compares them as readdatavalid returns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int MAX_BURST   = 16;
    localparam int MAX_PENDING = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] pending;
    logic       err_orphan;

    sdram_port_arbiter_if bus();

    sdram_port_arbiter #(
        .MAX_BURST   (MAX_BURST),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .pending    (pending),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tag;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    bit   acc_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 3;
    int peak     = 0;
    bit rsp_en   = 1'b1;
    bit log_en   = 1'b0;
    bit acc0     = 1'b0;
    bit acc1     = 1'b0;

    // Memory model contents: chosen so address 0x1000 reads 0xDEADBEEF
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEADAEEF;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Observe handshakes at the falling edge; feeds the scoreboard and checks returns
    task automatic monitor();
        exp_t e;
        rsp_t r;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (int'(pending) > peak) peak = int'(pending);
        if (bus.s_read && !bus.s_waitrequest) begin
            r.due  = cyc + 1 + lat;
            r.data = mem_data(bus.s_address);
            rsp_q.push_back(r);
        end
        if (bus.m0_read && !bus.m0_waitrequest) begin
            acc0   = 1'b1;
            e.tag  = 1'b0;
            e.data = mem_data(bus.m0_address);
            exp_q.push_back(e);
        end
        if ((bus.m1_read || bus.m1_write) && !bus.m1_waitrequest) begin
            acc1 = 1'b1;
            if (bus.m1_read) begin
                e.tag  = 1'b1;
                e.data = mem_data(bus.m1_address);
                exp_q.push_back(e);
            end
        end
        check_value("dual_grant", 32'(acc0 & acc1), 32'd0);
        if (acc0) check_value("m1_wait_in_own0", 32'(bus.m1_waitrequest), 32'd1);
        if (log_en && (acc0 || acc1)) acc_log.push_back(acc1);
        if (bus.m0_readdatavalid || bus.m1_readdatavalid) begin
            check_value("rdv_both", 32'(bus.m0_readdatavalid & bus.m1_readdatavalid), 32'd0);
            if (exp_q.size() == 0) begin
                check_value("rdv_queue_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_value("rdv_route", 32'(bus.m1_readdatavalid), 32'(e.tag));
                check_value("rdv_data",
                            bus.m1_readdatavalid ? bus.m1_readdata : bus.m0_readdata, e.data);
            end
        end
    endtask

    // One clock: sample at negedge, then the SDRAM responder drives after posedge
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_en) begin
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                bus.s_readdatavalid = 1'b1;
                bus.s_readdata      = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end else begin
                bus.s_readdatavalid = 1'b0;
                bus.s_readdata      = 32'h0;
            end
        end
        #1;
    endtask

    // Bound the run regardless of DUT behaviour
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;
        int left0;
        int left1;
        int turn;
        int idx;

        bus.m0_address      = 32'h0;
        bus.m0_read         = 1'b0;
        bus.m1_address      = 32'h0;
        bus.m1_read         = 1'b0;
        bus.m1_write        = 1'b0;
        bus.m1_writedata    = 32'h0;
        bus.m1_byteenable   = 4'h0;
        bus.s_readdata      = 32'h0;
        bus.s_waitrequest   = 1'b0;
        bus.s_readdatavalid = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        check_value("rst_pending", 32'(pending), 32'd0);
        check_value("rst_err", 32'(err_orphan), 32'd0);
        check_value("rst_s_read", 32'(bus.s_read), 32'd0);
        check_value("rst_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
        check_value("rst_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
        resetn = 1'b1;
        step();

        // ---- single M0 read, one-cycle forwarding latency ----
        bus.m0_address = 32'h1000;
        bus.m0_read    = 1'b1;
        #1;
        check_value("t1_idle_no_cmd", 32'(bus.s_read), 32'd0);
        step();
        check_value("t1_s_read", 32'(bus.s_read), 32'd1);
        check_value("t1_s_addr", bus.s_address, 32'h1000);
        check_value("t1_s_be", 32'(bus.s_byteenable), 32'hF);
        step();
        bus.m0_read = 1'b0;
        #1;
        check_value("t1_pending_1", 32'(pending), 32'd1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (bus.m0_readdatavalid) found = 1;
        end
        check_value("t1_rdv_seen", 32'(found), 32'd1);
        check_value("t1_rdata", bus.m0_readdata, 32'hDEADBEEF);
        check_value("t1_pending_pre_pop", 32'(pending), 32'd1);
        step();
        check_value("t1_pending_0", 32'(pending), 32'd0);
        step();

        // ---- stalled M1 write holds ownership ----
        bus.s_waitrequest = 1'b1;
        bus.m1_address    = 32'h2000;
        bus.m1_write      = 1'b1;
        bus.m1_writedata  = 32'h55AA00FF;
        bus.m1_byteenable = 4'b0011;
        step();
        bus.m0_address = 32'h3000;
        bus.m0_read    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_value("t3_s_write", 32'(bus.s_write), 32'd1);
            check_value("t3_s_wdata", bus.s_writedata, 32'h55AA00FF);
            check_value("t3_s_be", 32'(bus.s_byteenable), 32'h3);
            check_value("t3_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
            check_value("t3_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
            step();
        end
        bus.s_waitrequest = 1'b0;
        #1;
        check_value("t3_m1_go", 32'(bus.m1_waitrequest), 32'd0);
        step();
        check_value("t3_write_accepted", 32'(acc1), 32'd1);
        bus.m1_write = 1'b0;
        #1;
        check_value("t3_no_cmd", 32'(bus.s_read | bus.s_write), 32'd0);
        step();
        check_value("t3_m0_s_read", 32'(bus.s_read), 32'd1);
        check_value("t3_m0_s_addr", bus.s_address, 32'h3000);
        bus.m0_read = 1'b0;
        repeat (8) step();

        // ---- fairness: both masters requesting continuously ----
        lat = 2;
        acc_log.delete();
        log_en            = 1'b1;
        bus.m0_address    = 32'h4000;
        bus.m0_read       = 1'b1;
        bus.m1_address    = 32'h5000;
        bus.m1_write      = 1'b1;
        bus.m1_writedata  = 32'h12345678;
        bus.m1_byteenable = 4'hF;
        repeat (70) step();
        bus.m0_read  = 1'b0;
        bus.m1_write = 1'b0;
        log_en       = 1'b0;
        check_value("t2_accepts", 32'(acc_log.size() >= 64), 32'd1);
        for (int i = 0; i < 64; i++) begin
            if (i < acc_log.size()) check_value("t2_owner_seq", 32'(acc_log[i]), 32'((i / 16) % 2));
        end
        repeat (12) step();
        check_value("t2_drained", 32'(exp_q.size()), 32'd0);
        check_value("t2_pending", 32'(pending), 32'd0);

        // ---- interleaved reads, responses held until eight are outstanding ----
        lat    = 7;
        rsp_en = 1'b0;
        bus.s_readdatavalid = 1'b0;
        peak  = 0;
        left0 = 4;
        left1 = 4;
        turn  = 0;
        idx   = 0;
        for (int i = 0; i < 100 && (left0 > 0 || left1 > 0); i++) begin
            bus.m0_read    = (turn == 0 && left0 > 0);
            bus.m1_read    = (turn == 1 && left1 > 0);
            bus.m0_address = 32'h0100 + 32'(idx * 4);
            bus.m1_address = 32'h0200 + 32'(idx * 4);
            step();
            if (acc0) begin left0--; turn = 1; idx++; end
            if (acc1) begin left1--; turn = 0; idx++; end
        end
        bus.m1_read = 1'b0;
        check_value("t4_issued", 32'(left0 + left1), 32'd0);

        // ---- ninth read blocked by a full tag FIFO ----
        bus.m0_address = 32'h0900;
        bus.m0_read    = 1'b1;
        #1;
        check_value("t4_pending_8", 32'(pending), 32'd8);
        step();
        check_value("t5_blocked_read", 32'(bus.s_read), 32'd0);
        check_value("t5_blocked_wait", 32'(bus.m0_waitrequest), 32'd1);
        step();
        check_value("t5_still_blocked", 32'(bus.s_read), 32'd0);
        rsp_en = 1'b1;
        step();
        check_value("t5_first_rdv", 32'(bus.s_readdatavalid), 32'd1);
        check_value("t5_full_during_pop", 32'(bus.s_read), 32'd0);
        step();
        check_value("t5_ninth_issue", 32'(bus.s_read), 32'd1);
        check_value("t5_ninth_addr", bus.s_address, 32'h0900);
        check_value("t5_ninth_wait", 32'(bus.m0_waitrequest), 32'd0);
        step();
        bus.m0_read = 1'b0;
        repeat (30) step();
        check_value("t4_drained", 32'(exp_q.size()), 32'd0);
        check_value("t4_pending_0", 32'(pending), 32'd0);
        check_value("t4_peak", 32'(peak), 32'd8);
        check_value("t4_no_orphan", 32'(err_orphan), 32'd0);

        // ---- orphan response ----
        rsp_en              = 1'b0;
        bus.s_readdata      = 32'hCAFEF00D;
        bus.s_readdatavalid = 1'b1;
        #1;
        check_value("t6_no_fwd", 32'({bus.m1_readdatavalid, bus.m0_readdatavalid}), 32'd0);
        step();
        bus.s_readdatavalid = 1'b0;
        #1;
        check_value("t6_err_set", 32'(err_orphan), 32'd1);
        repeat (3) step();
        check_value("t6_err_sticky", 32'(err_orphan), 32'd1);

        // ---- reset mid-burst; late responses become orphans ----
        rsp_en         = 1'b1;
        lat            = 4;
        bus.m0_address = 32'h0A00;
        bus.m0_read    = 1'b1;
        repeat (4) step();
        check_value("t7_pending_pre_rst", 32'(pending != 6'd0), 32'd1);
        resetn      = 1'b0;
        bus.m0_read = 1'b0;
        #1;
        check_value("t7_rst_pending", 32'(pending), 32'd0);
        check_value("t7_rst_err", 32'(err_orphan), 32'd0);
        check_value("t7_rst_idle", 32'(bus.s_read), 32'd0);
        check_value("t7_rst_wait", 32'(bus.m0_waitrequest), 32'd1);
        exp_q.delete();
        step();
        resetn = 1'b1;
        repeat (15) step();
        check_value("t7_rsp_drained", 32'(rsp_q.size()), 32'd0);
        check_value("t7_orphan_after_rst", 32'(err_orphan), 32'd1);
        check_value("t7_pending_end", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM Avalon-MM master port between two requesters.
- M0 is the VGA scanout reader: read-only, high priority. M1 is the GPU/rasteriser: read/write.
- Tracks outstanding pipelined reads so each readdatavalid is returned to the master that issued the read.
- Prevents either master from monopolising the port.

Parameters:
- MAX_BURST, 16: accepted transfers an owner may complete while the other master waits, before it must yield (1..255).
- MAX_PENDING, 8: depth of the outstanding-read tag FIFO (power of 2, 2..32).

Ports:
- clk  in  1  system clock; all logic in this domain
- resetn  in  1  asynchronous active-low reset
- m0_address  in  32  VGA read address
- m0_read  in  1  VGA read request
- m0_readdata  out  32  read data to VGA
- m0_waitrequest  out  1  stall to VGA
- m0_readdatavalid  out  1  VGA read data valid
- m1_address  in  32  GPU address
- m1_read  in  1  GPU read request
- m1_write  in  1  GPU write request
- m1_writedata  in  32  GPU write data
- m1_byteenable  in  4  GPU byte enables
- m1_readdata  out  32  read data to GPU
- m1_waitrequest  out  1  stall to GPU
- m1_readdatavalid  out  1  GPU read data valid
- s_address  out  32  SDRAM address
- s_read  out  1  SDRAM read
- s_write  out  1  SDRAM write
- s_writedata  out  32  SDRAM write data
- s_byteenable  out  4  SDRAM byte enables
- s_readdata  in  32  SDRAM read data
- s_waitrequest  in  1  SDRAM stall
- s_readdatavalid  in  1  SDRAM read data valid
- pending  out  6  outstanding reads (debug)
- err_orphan  out  1  sticky: readdatavalid arrived with no outstanding read

Behaviour:
Definitions:
- req0 = m0_read; req1 = m1_read | m1_write. M1 asserting read and write together is illegal; the read takes effect.
- blocked = owner presents a read && FIFO full.
- accept = owner request && !s_waitrequest && !blocked.

States (registered): IDLE, OWN0, OWN1. Reset -> IDLE, burst count 0, FIFO empty, err_orphan 0.
- IDLE: req0 -> OWN0; else req1 -> OWN1; else stay. No command is issued in IDLE, so the first command is forwarded one cycle after the request is seen.
- OWNx, owner requesting:
  - Forward the owner's command combinationally to the s_ port. Drive byteenable 4'hF for M0.
  - mx_waitrequest = s_waitrequest | blocked.
  - On accept, increment the burst count.
  - If the other master is requesting and the count reaches MAX_BURST on this accept -> OWNother, count cleared.
- OWNx, owner not requesting: other requesting -> OWNother; else -> IDLE. Count cleared.
- Ownership never changes while a command is stalled (request high, not accepted). The count is cleared on every state change.
- Non-owner: waitrequest = 1. Outside ownership, all s_ command outputs are 0 and address/writedata are 0.
- Blocked read: s_read = 0 and owner waitrequest = 1 until a slot frees. Writes are never blocked by the FIFO.

Read tag FIFO:
- 1-bit tag = issuing master.
- Push on an accepted read. Pop on s_readdatavalid.
- Push is refused when full, even if a pop occurs in the same cycle. Simultaneous push/pop when not full leaves the count unchanged.
- mX_readdatavalid = s_readdatavalid && FIFO non-empty && head tag == X.
- m0_readdata and m1_readdata are both s_readdata, with no added latency.
- s_readdatavalid with the FIFO empty: no valid forwarded, err_orphan set until reset.
- pending = FIFO occupancy; reset value 0.

Ordering and reset:
- Reads return strictly in issue order across both masters.
- Reset asserted mid-transfer clears everything immediately. Responses for reads issued before reset count as orphans.

Test Plan:
- Reset, then m0_read at 0x1000 with s_waitrequest=0 -> s_read high 1 cycle after request with s_address=0x1000. s_readdatavalid with 0xDEADBEEF -> m0_readdatavalid=1, m0_readdata=0xDEADBEEF, pending 1->0.
- Both masters requesting continuously, MAX_BURST=16, no stalls -> exactly 16 M0 reads accepted, then ownership passes to M1. M1 gets 16 accepts, the pattern repeats, and m1_waitrequest=1 throughout M0 ownership.
- M1 write 0x55AA00FF, byteenable 4'b0011, with s_waitrequest high for 5 cycles and m0_read raised meanwhile -> s_write/s_writedata held stable for all 5 cycles, no switch to M0 before the write is accepted.
- Interleaved M0 and M1 reads, 4 each, returned in order with latency 7 -> each readdatavalid routed to the issuing master in exact issue order; pending peaks at 8.
- MAX_PENDING=8 with 8 reads outstanding and a 9th requested -> s_read=0, waitrequest=1. The first s_readdatavalid frees a slot and the 9th issues the following cycle.
- s_readdatavalid pulsed with pending=0 -> no mX_readdatavalid, err_orphan=1. err_orphan persists until resetn is low, and resetn low mid-burst returns to IDLE with pending=0.
